// File: rtl/uart_cmd_parser.sv
// Assembles 6-byte command frames (sync, sync, addr, data hi, data lo, checksum)
// from the UART receiver handshake and issues one-cycle configuration writes.
module uart_cmd_parser #(
  parameter int unsigned CLK_FRE    = 50,
  parameter int unsigned TIMEOUT_US = 1000,
  parameter logic [7:0]  HDR0_BYTE  = 8'h55,
  parameter logic [7:0]  HDR1_BYTE  = 8'hAA
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_rdy,
  output logic        rx_ack,
  output logic        cfg_wr,
  output logic [7:0]  cfg_addr,
  output logic [15:0] cfg_wdata,
  output logic        frame_err,
  output logic        frame_tmo,
  output logic [7:0]  err_cnt
);

  localparam int unsigned TIMEOUT = CLK_FRE * TIMEOUT_US;
  localparam int unsigned TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_ADDR,
    S_DHI,
    S_DLO,
    S_CSUM
  } state_t;

  state_t        state, state_next;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    sum;
  logic [7:0]    addr_tmp;
  logic [7:0]    dhi_tmp;
  logic [7:0]    dlo_tmp;
  logic          armed;
  logic          accept;
  logic          tmo_hit;
  logic          csum_ok;
  logic          wr_set;
  logic          ferr_set;
  logic          err_inc;

  // A held-high rx_rdy is consumed once: re-arm only after it has been seen low.
  assign accept  = rx_rdy && !rx_ack && armed;
  assign tmo_hit = (state != S_HDR0) && !accept && (tmo_cnt == TMO_LAST);
  assign csum_ok = (rx_data == sum);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_HDR0;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; an accept in the timeout cycle takes priority
  always_comb begin
    state_next = state;
    if (accept) begin
      unique case (state)
        S_HDR0:  state_next = (rx_data == HDR0_BYTE) ? S_HDR1 : S_HDR0;
        S_HDR1: begin
          if (rx_data == HDR1_BYTE)      state_next = S_ADDR;
          else if (rx_data == HDR0_BYTE) state_next = S_HDR1;
          else                           state_next = S_HDR0;
        end
        S_ADDR:  state_next = S_DHI;
        S_DHI:   state_next = S_DLO;
        S_DLO:   state_next = S_CSUM;
        S_CSUM:  state_next = S_HDR0;
        default: state_next = S_HDR0;
      endcase
    end else if (tmo_hit) begin
      state_next = S_HDR0;
    end
  end

  // Output decode feeding the registered outputs
  always_comb begin
    wr_set   = 1'b0;
    ferr_set = 1'b0;
    if (accept && (state == S_CSUM)) begin
      wr_set   = csum_ok;
      ferr_set = !csum_ok;
    end
    err_inc = ferr_set || tmo_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ack    <= 1'b0;
      cfg_wr    <= 1'b0;
      cfg_addr  <= '0;
      cfg_wdata <= '0;
      frame_err <= 1'b0;
      frame_tmo <= 1'b0;
      err_cnt   <= '0;
      tmo_cnt   <= '0;
      sum       <= '0;
      addr_tmp  <= '0;
      dhi_tmp   <= '0;
      dlo_tmp   <= '0;
      armed     <= 1'b1;
    end else begin
      rx_ack    <= accept;
      cfg_wr    <= wr_set;
      frame_err <= ferr_set;
      frame_tmo <= tmo_hit;

      if (!rx_rdy)     armed <= 1'b1;
      else if (accept) armed <= 1'b0;

      if (wr_set) begin
        cfg_addr  <= addr_tmp;
        cfg_wdata <= {dhi_tmp, dlo_tmp};
      end

      if (err_inc && (err_cnt != '1)) err_cnt <= err_cnt + 8'd1;

      if (accept || tmo_hit || (state == S_HDR0)) tmo_cnt <= '0;
      else                                          tmo_cnt <= tmo_cnt + TW'(1);

      if (accept) begin
        unique case (state)
          S_ADDR: begin
            addr_tmp <= rx_data;
            sum      <= rx_data;
          end
          S_DHI: begin
            dhi_tmp <= rx_data;
            sum     <= sum + rx_data;
          end
          S_DLO: begin
            dlo_tmp <= rx_data;
            sum     <= sum + rx_data;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: vector table, directed corner sequences and a
// randomized byte stream checked against a queue-based frame model.
module tb_uart_cmd_parser;

  localparam int unsigned TMO = 50;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic        rx_ack;
  logic        cfg_wr;
  logic [7:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        frame_err;
  logic        frame_tmo;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  uart_cmd_parser #(
    .CLK_FRE   (50),
    .TIMEOUT_US(1),
    .HDR0_BYTE (8'h55),
    .HDR1_BYTE (8'hAA)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_rdy   (rx_rdy),
    .rx_ack   (rx_ack),
    .cfg_wr   (cfg_wr),
    .cfg_addr (cfg_addr),
    .cfg_wdata(cfg_wdata),
    .frame_err(frame_err),
    .frame_tmo(frame_tmo),
    .err_cnt  (err_cnt)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle counter and pulse monitor
  int unsigned cyc = 0;
  int unsigned n_ack = 0, n_wr = 0, n_ferr = 0, n_tmo = 0, n_wide = 0, tmo_cyc = 0;
  logic prev_ack = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ack = 1'b0;
    end else begin
      if (rx_ack) n_ack++;
      if (rx_ack && prev_ack) n_wide++;
      prev_ack = rx_ack;
      if (cfg_wr) n_wr++;
      if (frame_err) n_ferr++;
      if (frame_tmo) begin
        n_tmo++;
        tmo_cyc = cyc;
      end
    end
  end

  // Values observed at the negedge following an accepted byte
  logic        o_wr, o_ferr, o_tmo;
  logic [7:0]  o_addr, o_err;
  logic [15:0] o_wdata;
  int unsigned o_gap, last_acc = 0;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned idle);
    bit got = 0;
    rx_data = b;
    rx_rdy  = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (rx_ack) got = 1;
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ack_wait: got no rx_ack expected one for byte 0x%0h", b);
    end
    o_wr     = cfg_wr;
    o_ferr   = frame_err;
    o_tmo    = frame_tmo;
    o_addr   = cfg_addr;
    o_wdata  = cfg_wdata;
    o_err    = err_cnt;
    o_gap    = cyc - last_acc;
    last_acc = cyc;
    rx_rdy   = 1'b0;
    tick();
    repeat (idle) tick();
  endtask

  task automatic do_reset();
    rx_rdy = 1'b0;
    rst_n  = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic send6(input logic [47:0] f);
    for (int k = 0; k < 6; k++) send_byte(f[47-8*k -: 8], 0);
  endtask

  // Queue-based frame model
  logic [7:0]  mq[$];
  logic [7:0]  m_addr;
  logic [15:0] m_data;
  int unsigned m_err, m_tmo, m_ferr, m_wr;
  logic        e_wr, e_ferr;

  task automatic m_bump();
    m_err = (m_err == 255) ? 255 : m_err + 1;
  endtask

  task automatic model_byte(input logic [7:0] b, input int unsigned gap);
    logic [7:0] s;
    e_wr   = 1'b0;
    e_ferr = 1'b0;
    if (mq.size() != 0 && gap > TMO) begin
      mq.delete();
      m_tmo++;
      m_bump();
    end
    if (mq.size() == 0) begin
      if (b == 8'h55) mq.push_back(b);
    end else if (mq.size() == 1) begin
      if (b == 8'hAA) mq.push_back(b);
      else if (b != 8'h55) mq.delete();
    end else begin
      mq.push_back(b);
      if (mq.size() == 6) begin
        s = mq[2] + mq[3] + mq[4];
        if (s == mq[5]) begin
          e_wr   = 1'b1;
          m_addr = mq[2];
          m_data = {mq[3], mq[4]};
          m_wr++;
        end else begin
          e_ferr = 1'b1;
          m_ferr++;
          m_bump();
        end
        mq.delete();
      end
    end
  endtask

  typedef struct {
    logic [47:0] bytes;
    logic        exp_wr;
    logic        exp_ferr;
    logic [7:0]  exp_addr;
    logic [15:0] exp_wdata;
    logic [7:0]  exp_err;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned s_ack, s_wr, s_tmo, s_ferr, acc;
    logic [7:0] q8[$];

    tbl[0] = '{48'h55AA10123456, 1'b1, 1'b0, 8'h10, 16'h1234, 8'd0};
    tbl[1] = '{48'h55AA10123457, 1'b0, 1'b1, 8'h10, 16'h1234, 8'd1};
    tbl[2] = '{48'h55AA55AA5554, 1'b1, 1'b0, 8'h55, 16'hAA55, 8'd1};
    tbl[3] = '{48'h55AAFFFFFFFD, 1'b1, 1'b0, 8'hFF, 16'hFFFF, 8'd1};
    tbl[4] = '{48'h55AA00000000, 1'b1, 1'b0, 8'h00, 16'h0000, 8'd1};
    tbl[5] = '{48'h55AA01020307, 1'b0, 1'b1, 8'h00, 16'h0000, 8'd2};

    rx_data = '0;
    do_reset();
    check("rst_ack", rx_ack, 0);
    check("rst_wr", cfg_wr, 0);
    check("rst_addr", cfg_addr, 0);
    check("rst_wdata", cfg_wdata, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_tmo", frame_tmo, 0);
    check("rst_errcnt", err_cnt, 0);

    for (int v = 0; v < 6; v++) begin
      s_ack = n_ack;
      s_wr  = n_wr;
      send6(tbl[v].bytes);
      check($sformatf("tbl%0d_wr", v), o_wr, tbl[v].exp_wr);
      check($sformatf("tbl%0d_ferr", v), o_ferr, tbl[v].exp_ferr);
      check($sformatf("tbl%0d_addr", v), o_addr, tbl[v].exp_addr);
      check($sformatf("tbl%0d_wdata", v), o_wdata, tbl[v].exp_wdata);
      check($sformatf("tbl%0d_errcnt", v), o_err, tbl[v].exp_err);
      check($sformatf("tbl%0d_acks", v), n_ack - s_ack, 6);
      check($sformatf("tbl%0d_wr_pulses", v), n_wr - s_wr, 32'(tbl[v].exp_wr));
    end

    // Junk and repeated sync ahead of a frame whose checksum wraps to zero
    q8 = '{8'h00, 8'h55, 8'h55, 8'hAA, 8'h01, 8'h00, 8'hFF, 8'h00};
    s_wr = n_wr;
    foreach (q8[i]) send_byte(q8[i], 0);
    check("resync_wr", o_wr, 1);
    check("resync_addr", o_addr, 8'h01);
    check("resync_wdata", o_wdata, 16'h00FF);
    check("resync_wr_pulses", n_wr - s_wr, 1);
    check("resync_errcnt", o_err, 2);

    // Stalled frame times out 50 cycles after its last accepted byte
    s_tmo = n_tmo;
    send_byte(8'h55, 0);
    send_byte(8'hAA, 0);
    send_byte(8'h20, 0);
    acc = last_acc;
    repeat (60) tick();
    check("tmo_pulses", n_tmo - s_tmo, 1);
    check("tmo_latency", tmo_cyc - acc, TMO);
    check("tmo_errcnt", err_cnt, 3);
    send6(48'h55AA20000121);
    check("after_tmo_wr", o_wr, 1);
    check("after_tmo_addr", o_addr, 8'h20);
    check("after_tmo_wdata", o_wdata, 16'h0001);

    // Gap of exactly the timeout: accept wins; one cycle longer: timeout
    s_tmo = n_tmo;
    send_byte(8'h55, 0);
    send_byte(8'hAA, 0);
    send_byte(8'h21, 48);
    send_byte(8'h00, 0);
    check("gap50_tmo", o_tmo, 0);
    check("gap50_tmo_pulses", n_tmo - s_tmo, 0);
    send_byte(8'h01, 0);
    send_byte(8'h22, 0);
    check("gap50_wr", o_wr, 1);
    check("gap50_addr", o_addr, 8'h21);
    check("gap50_errcnt", o_err, 3);
    send_byte(8'h55, 0);
    send_byte(8'hAA, 0);
    send_byte(8'h21, 49);
    send_byte(8'h00, 0);
    check("gap51_tmo_pulses", n_tmo - s_tmo, 1);
    check("gap51_errcnt", o_err, 4);
    send6(48'h55AA05000005);
    check("gap51_next_addr", o_addr, 8'h05);
    check("gap51_next_wdata", o_wdata, 16'h0000);

    // rx_rdy held high for several cycles is consumed once
    send_byte(8'h55, 0);
    s_ack   = n_ack;
    rx_data = 8'hAA;
    rx_rdy  = 1'b1;
    repeat (5) tick();
    rx_rdy = 1'b0;
    tick();
    check("hold_acks", n_ack - s_ack, 1);
    send_byte(8'h10, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'h56, 0);
    check("hold_wr", o_wr, 1);
    check("hold_addr", o_addr, 8'h10);
    check("hold_wdata", o_wdata, 16'h1234);

    // Reset mid-frame discards the partial frame
    send_byte(8'h55, 0);
    send_byte(8'hAA, 0);
    send_byte(8'h30, 0);
    send_byte(8'h12, 0);
    rst_n = 1'b0;
    tick();
    check("midrst_addr", cfg_addr, 0);
    check("midrst_errcnt", err_cnt, 0);
    tick();
    rst_n = 1'b1;
    tick();
    s_wr = n_wr;
    send_byte(8'h34, 0);
    send_byte(8'h46, 0);
    check("midrst_no_wr", n_wr - s_wr, 0);
    send6(48'h55AA30123476);
    check("midrst_wr", o_wr, 1);
    check("midrst_addr2", o_addr, 8'h30);
    check("midrst_wdata", o_wdata, 16'h1234);
    check("midrst_errcnt2", o_err, 0);

    // Randomized stream against the frame model
    do_reset();
    mq.delete();
    m_addr = '0;
    m_data = '0;
    m_err  = 0;
    m_tmo  = 0;
    m_ferr = 0;
    m_wr   = 0;
    s_tmo  = n_tmo;
    s_ferr = n_ferr;
    s_wr   = n_wr;
    for (int f = 0; f < 300; f++) begin
      int unsigned kind, len, longpos;
      logic [7:0] a, h, l, c;
      kind = $urandom_range(0, 9);
      a = 8'($urandom);
      h = 8'($urandom);
      l = 8'($urandom);
      c = a + h + l;
      if (kind == 1) c = c ^ 8'($urandom_range(1, 255));
      q8 = '{8'h55, 8'hAA, a, h, l, c};
      if (kind == 0) q8 = '{8'($urandom)};
      len = (kind == 2) ? $urandom_range(1, 5) : q8.size();
      longpos = (kind == 3) ? $urandom_range(0, 4) : 99;
      for (int j = 0; j < int'(len); j++) begin
        int unsigned idle;
        idle = $urandom_range(0, 3);
        if ((kind == 2 && j == int'(len) - 1) || j == int'(longpos))
          idle = $urandom_range(45, 55);
        send_byte(q8[j], idle);
        model_byte(q8[j], o_gap);
        check("rnd_wr", o_wr, e_wr);
        check("rnd_ferr", o_ferr, e_ferr);
        check("rnd_tmo", o_tmo, 0);
        check("rnd_addr", o_addr, m_addr);
        check("rnd_wdata", o_wdata, m_data);
        check("rnd_errcnt", o_err, m_err);
      end
    end
    repeat (60) tick();
    if (mq.size() != 0) begin
      m_tmo++;
      m_bump();
    end
    check("rnd_tmo_total", n_tmo - s_tmo, m_tmo);
    check("rnd_ferr_total", n_ferr - s_ferr, m_ferr);
    check("rnd_wr_total", n_wr - s_wr, m_wr);
    check("rnd_errcnt_final", err_cnt, m_err);

    // Error counter saturation
    do_reset();
    s_ferr = n_ferr;
    for (int f = 0; f < 260; f++) send6(48'h55AA00000001);
    check("sat_errcnt", err_cnt, 255);
    check("sat_ferr_pulses", n_ferr - s_ferr, 260);
    send6(48'h55AA00000001);
    check("sat_hold", o_err, 255);

    check("ack_width", n_wide, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
